// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants: FK, CK generator parameters, round count,
// controller state encoding and the SM4 S-box.
package sm4_pkg;

    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [7:0] CK_INC  = 8'd28;
    localparam logic [7:0] CK_OFF0 = 8'd0;
    localparam logic [7:0] CK_OFF1 = 8'd7;
    localparam logic [7:0] CK_OFF2 = 8'd14;
    localparam logic [7:0] CK_OFF3 = 8'd21;

    localparam int ROUNDS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXP   = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'hD690E9FECCE13DB716B614C228FB2C05,
        128'h2B679A762ABE04C3AA44132649860699,
        128'h9C4250F491EF987A33540B43EDCFAC62,
        128'hE4B31CA9C908E89580DF94FA758F3FA6,
        128'h4707A7FCF37317BA83593C19E6854FA8,
        128'h686B81B27164DA8BF8EB0F4B70569D35,
        128'h1E240E5E6358D1A225227C3B01217887,
        128'hD40046579FD327524C3602E7A0C4C89E,
        128'hEABF8AD240C738B5A3F7F2CEF96115A1,
        128'hE0AE5DA49B341A55AD933230F58CB1E3,
        128'h1DF6E22E8266CA60C02923AB0D534E6F,
        128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
        128'h8D1BAF92BBDDBC7F11D95C411F105AD8,
        128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
        128'h8969974A0C96777E65B9F109C56EC684,
        128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 2040 - 8 * int'(x);
        return SBOX_TABLE[idx +: 8];
    endfunction

endpackage

// File: rtl/sm4_key_sched_ctrl_round.sv
// One SM4 key-expansion round: rk = K0 ^ T'(K1 ^ K2 ^ K3 ^ CK).
module sm4_key_sched_ctrl_round
    import sm4_pkg::*;
(
    input  logic [127:0] k_in,
    input  logic [31:0]  ck_in,
    output logic [31:0]  rk_out
);

    logic [31:0] x_s;
    logic [31:0] b_s;

    // Nonlinear S-box layer followed by the key-schedule linear transform L'.
    always_comb begin
        x_s    = k_in[95:64] ^ k_in[63:32] ^ k_in[31:0] ^ ck_in;
        b_s    = {sbox(x_s[31:24]), sbox(x_s[23:16]), sbox(x_s[15:8]), sbox(x_s[7:0])};
        rk_out = k_in[127:96] ^ b_s ^ {b_s[18:0], b_s[31:19]} ^ {b_s[8:0], b_s[31:9]};
    end

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-schedule controller: expands a 128-bit master key into 32 round keys,
// one per cycle, streams them out and keeps them in a readable 32-entry store.
module sm4_key_sched_ctrl
    import sm4_pkg::*;
#(
    parameter int RD_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         key_clear,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         rk_out_valid,
    output logic [4:0]   rk_out_idx,
    output logic [31:0]  rk_out,
    input  logic [4:0]   rd_idx,
    input  logic         rd_dec,
    output logic [31:0]  rd_data
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t       state_q, state_d;
    logic [127:0] k_q, k_d;
    logic [4:0]   round_q, round_d;
    logic [7:0]   ck_acc_q, ck_acc_d;
    logic         keys_valid_q, keys_valid_d;
    logic         done_q, done_d;
    logic         rk_out_valid_q, rk_out_valid_d;
    logic [4:0]   rk_out_idx_q, rk_out_idx_d;
    logic [31:0]  rk_out_q, rk_out_d;
    logic         mem_we_s;
    logic [31:0]  ck_s;
    logic [31:0]  rk_s;
    logic [4:0]   rd_addr_s;
    logic [31:0]  mem_q [ROUNDS];

    assign ck_s = {ck_acc_q + CK_OFF0, ck_acc_q + CK_OFF1, ck_acc_q + CK_OFF2, ck_acc_q + CK_OFF3};

    sm4_key_sched_ctrl_round u_round (
        .k_in   (k_q),
        .ck_in  (ck_s),
        .rk_out (rk_s)
    );

    // Next-state logic; key_clear overrides any accept or round in progress.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        round_d        = round_q;
        ck_acc_d       = ck_acc_q;
        keys_valid_d   = keys_valid_q;
        done_d         = 1'b0;
        rk_out_valid_d = 1'b0;
        rk_out_idx_d   = rk_out_idx_q;
        rk_out_d       = rk_out_q;
        mem_we_s       = 1'b0;
        if (key_clear) begin
            state_d      = ST_IDLE;
            keys_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (key_valid) begin
                        state_d      = ST_EXP;
                        k_d          = key_in ^ FK;
                        round_d      = 5'd0;
                        ck_acc_d     = 8'd0;
                        keys_valid_d = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_EXP: begin
                    mem_we_s       = 1'b1;
                    k_d            = {k_q[95:0], rk_s};
                    rk_out_d       = rk_s;
                    rk_out_idx_d   = round_q;
                    rk_out_valid_d = 1'b1;
                    round_d        = round_q + 5'd1;
                    ck_acc_d       = ck_acc_q + CK_INC;
                    if (round_q == LAST_ROUND) begin
                        state_d      = ST_READY;
                        keys_valid_d = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        state_d = ST_EXP;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    keys_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Controller state and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            k_q            <= 128'd0;
            round_q        <= 5'd0;
            ck_acc_q       <= 8'd0;
            keys_valid_q   <= 1'b0;
            done_q         <= 1'b0;
            rk_out_valid_q <= 1'b0;
            rk_out_idx_q   <= 5'd0;
            rk_out_q       <= 32'd0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            round_q        <= round_d;
            ck_acc_q       <= ck_acc_d;
            keys_valid_q   <= keys_valid_d;
            done_q         <= done_d;
            rk_out_valid_q <= rk_out_valid_d;
            rk_out_idx_q   <= rk_out_idx_d;
            rk_out_q       <= rk_out_d;
        end
    end

    // Round-key store; contents survive reset and key_clear.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[round_q] <= rk_s;
        end
    end

    assign rd_addr_s    = rd_dec ? (5'd31 - rd_idx) : rd_idx;
    assign key_ready    = (state_q != ST_EXP) && !key_clear;
    assign busy         = (state_q == ST_EXP);
    assign done         = done_q;
    assign keys_valid   = keys_valid_q;
    assign rk_out_valid = rk_out_valid_q;
    assign rk_out_idx   = rk_out_idx_q;
    assign rk_out       = rk_out_q;

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [31:0] rd_data_q;
            logic [31:0] rd_data_d;
            assign rd_data_d = mem_q[rd_addr_s];
            // One-cycle registered read port.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= 32'd0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end
            assign rd_data = rd_data_q;
        end else begin : g_rd_comb
            assign rd_data = mem_q[rd_addr_s];
        end
    endgenerate

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Self-checking bench for sm4_key_sched_ctrl: a combinational-read and a
// registered-read instance share stimulus and are checked against a reference model.
module tb_sm4_key_sched_ctrl;
    import sm4_pkg::*;

    typedef logic [31:0] rk_arr_t [32];
    typedef struct {
        logic [127:0] key;
        logic [4:0]   idx;
        logic         dec;
        logic [31:0]  exp_rd;
    } vec_t;

    localparam logic [127:0] KAT_KEY = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_clear = 1'b0;
    logic [127:0] key_in = 128'd0;
    logic [4:0]   rd_idx = 5'd0;
    logic         rd_dec = 1'b0;

    logic        key_ready_a, busy_a, done_a, keys_valid_a, rk_out_valid_a;
    logic [4:0]  rk_out_idx_a;
    logic [31:0] rk_out_a, rd_data_a;
    logic        key_ready_b, busy_b, done_b, keys_valid_b, rk_out_valid_b;
    logic [4:0]  rk_out_idx_b;
    logic [31:0] rk_out_b, rd_data_b;

    int checks = 0;
    int errors = 0;
    rk_arr_t mem_model;
    logic [31:0] prev_rd;
    bit prev_ok = 1'b0;

    sm4_key_sched_ctrl #(.RD_REG(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready_a),
        .key_in(key_in), .key_clear(key_clear), .busy(busy_a), .done(done_a),
        .keys_valid(keys_valid_a), .rk_out_valid(rk_out_valid_a), .rk_out_idx(rk_out_idx_a),
        .rk_out(rk_out_a), .rd_idx(rd_idx), .rd_dec(rd_dec), .rd_data(rd_data_a)
    );

    sm4_key_sched_ctrl #(.RD_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready_b),
        .key_in(key_in), .key_clear(key_clear), .busy(busy_b), .done(done_b),
        .keys_valid(keys_valid_b), .rk_out_valid(rk_out_valid_b), .rk_out_idx(rk_out_idx_b),
        .rk_out(rk_out_b), .rd_idx(rd_idx), .rd_dec(rd_dec), .rd_data(rd_data_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_tp(input logic [31:0] x);
        logic [31:0] b;
        b = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
        return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
    endfunction

    // Textbook key schedule over the K[0..35] word sequence.
    task automatic ref_expand(input logic [127:0] key, output rk_arr_t rk);
        logic [31:0]  k [36];
        logic [127:0] kx;
        logic [31:0]  ck;
        kx = key ^ 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
        k[0] = kx[127:96]; k[1] = kx[95:64]; k[2] = kx[63:32]; k[3] = kx[31:0];
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
            k[i+4] = k[i] ^ ref_tp(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            rk[i]  = k[i+4];
        end
    endtask

    task automatic check_reset_outputs();
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_keys_valid", keys_valid_a, 1'b0);
        chk1("rst_rk_out_valid", rk_out_valid_a, 1'b0);
        chk32("rst_rk_out", rk_out_a, 32'd0);
        chk32("rst_rk_out_idx", {27'd0, rk_out_idx_a}, 32'd0);
        chk1("rst_key_ready", key_ready_a, 1'b1);
        chk32("rst_rd_data_reg", rd_data_b, 32'd0);
        chk1("rst_done_b", done_b, 1'b0);
    endtask

    // Offer a key and return just after the accepting clock edge T.
    task automatic accept(input logic [127:0] key, input logic keep);
        @(negedge clk);
        key_in = key; key_valid = 1'b1; key_clear = 1'b0;
        for (int n = 0; n < 100 && !key_ready_a; n++) @(negedge clk);
        if (!key_ready_a) begin
            checks++; errors++;
            $display("FAIL accept_timeout: key_ready got 0 for 100 cycles, expected 1");
        end
        @(posedge clk);
        #1 key_valid = keep;
        prev_ok = 1'b0;
    endtask

    // Check cycles T+1..T+nk after an accept at edge T.
    task automatic check_stream(input rk_arr_t rk, input int nk);
        for (int k = 1; k <= nk; k++) begin
            @(negedge clk);
            chk1("rk_out_valid", rk_out_valid_a, (k >= 2 && k <= 33));
            if (k >= 2 && k <= 33) begin
                chk32("rk_out_idx", {27'd0, rk_out_idx_a}, 32'(k - 2));
                chk32("rk_out", rk_out_a, rk[k-2]);
                chk32("rk_out_b", rk_out_b, rk[k-2]);
            end
            chk1("done", done_a, k == 33);
            chk1("keys_valid", keys_valid_a, k >= 33);
            chk1("busy", busy_a, k <= 32);
            chk1("key_ready", key_ready_a, k >= 33);
        end
    endtask

    task automatic run_full(input logic [127:0] key);
        rk_arr_t rk;
        ref_expand(key, rk);
        accept(key, 1'b0);
        check_stream(rk, 34);
        mem_model = rk;
    endtask

    task automatic check_read(input logic [4:0] idx, input logic dec, input logic [31:0] exp);
        rd_idx = idx; rd_dec = dec;
        #1;
        chk32("rd_data_comb", rd_data_a, exp);
        if (prev_ok) chk32("rd_data_reg_latency", rd_data_b, prev_rd);
        @(posedge clk);
        #1 chk32("rd_data_reg", rd_data_b, exp);
        prev_rd = exp;
        prev_ok = 1'b1;
    endtask

    initial begin
        vec_t         vecs [6];
        rk_arr_t      rk_a, rk_b, old_mem;
        logic [127:0] loaded;
        bit           have;
        logic [127:0] rkey;
        logic [4:0]   ridx;
        logic         rdec;

        vecs = '{
            '{KAT_KEY, 5'd0,  1'b1, 32'h9124A012},
            '{KAT_KEY, 5'd0,  1'b0, 32'hF12186F9},
            '{KAT_KEY, 5'd1,  1'b0, 32'h41662B61},
            '{KAT_KEY, 5'd31, 1'b0, 32'h9124A012},
            '{KAT_KEY, 5'd31, 1'b1, 32'hF12186F9},
            '{KAT_KEY, 5'd30, 1'b1, 32'h41662B61}
        };
        have = 1'b0;
        loaded = 128'd0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Known-answer vectors, both read orders and both read-port variants.
        for (int v = 0; v < 6; v++) begin
            if (!have || vecs[v].key != loaded) begin
                run_full(vecs[v].key);
                loaded = vecs[v].key;
                have = 1'b1;
            end
            check_read(vecs[v].idx, vecs[v].dec, vecs[v].exp_rd);
        end

        // Random keys against the reference model.
        for (int r = 0; r < 3; r++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_full(rkey);
            for (int q = 0; q < 4; q++) begin
                ridx = 5'($urandom_range(0, 31));
                rdec = 1'($urandom_range(0, 1));
                check_read(ridx, rdec, mem_model[rdec ? 5'd31 - ridx : ridx]);
            end
        end

        // key_valid held through EXP: second key waits for READY, then a fresh stream.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        ref_expand(rkey, rk_a);
        accept(rkey, 1'b1);
        rkey = {$urandom, $urandom, $urandom, $urandom};
        ref_expand(rkey, rk_b);
        key_in = rkey;
        check_stream(rk_a, 33);
        @(posedge clk);
        #1 key_valid = 1'b0;
        check_stream(rk_b, 34);
        mem_model = rk_b;
        check_read(5'd5, 1'b0, rk_b[5]);

        // key_clear while round 10 is being computed.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        ref_expand(rkey, rk_a);
        old_mem = mem_model;
        accept(rkey, 1'b0);
        check_stream(rk_a, 11);
        key_clear = 1'b1;
        @(negedge clk);
        chk1("clr_rk_out_valid", rk_out_valid_a, 1'b0);
        chk1("clr_done", done_a, 1'b0);
        chk1("clr_keys_valid", keys_valid_a, 1'b0);
        chk1("clr_busy", busy_a, 1'b0);
        chk1("clr_key_ready_while_clear", key_ready_a, 1'b0);
        chk32("clr_rk_out_hold", rk_out_a, rk_a[9]);
        chk32("clr_rk_out_idx_hold", {27'd0, rk_out_idx_a}, 32'd9);
        key_clear = 1'b0;
        #1 chk1("clr_key_ready", key_ready_a, 1'b1);
        @(negedge clk);
        key_clear = 1'b1; key_valid = 1'b1; key_in = KAT_KEY;
        #1 chk1("clr_valid_key_ready", key_ready_a, 1'b0);
        @(negedge clk);
        chk1("clr_valid_no_accept", busy_a, 1'b0);
        key_clear = 1'b0; key_valid = 1'b0;
        @(negedge clk);
        chk1("clr_done_after", done_a, 1'b0);
        for (int i = 0; i < 32; i++) mem_model[i] = (i < 10) ? rk_a[i] : old_mem[i];
        check_read(5'd9, 1'b0, mem_model[9]);
        check_read(5'd10, 1'b0, mem_model[10]);
        check_read(5'd21, 1'b1, mem_model[10]);

        // Reset asserted while round 20 is being computed.
        rkey = {$urandom, $urandom, $urandom, $urandom};
        ref_expand(rkey, rk_a);
        accept(rkey, 1'b0);
        check_stream(rk_a, 21);
        rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        prev_ok = 1'b0;
        #1 chk1("post_rst_key_ready", key_ready_a, 1'b1);
        run_full(KAT_KEY);
        check_read(5'd0, 1'b0, 32'hF12186F9);
        check_read(5'd1, 1'b0, 32'h41662B61);
        check_read(5'd0, 1'b1, 32'h9124A012);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
